// File: rtl/seg_pkg.sv
// Shared seven-segment constants and types used by the display driver and seg_reader.
// Segment codes are active-low, bit6 = a .. bit0 = g.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [1:0] DIG_TENS  = 2'b10;
   localparam logic [1:0] DIG_UNITS = 2'b01;

   typedef enum logic {
      S_TENS  = 1'b0,
      S_UNITS = 1'b1
   } rd_state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] digit;
   } digit_t;

   // Two-digit frame value; the tens position is only ever 0 or 1.
   function automatic logic [4:0] frame_value(input logic tens, input logic [3:0] units);
      logic [4:0] base;
      if (tens) begin
         base = 5'd10;
      end else begin
         base = 5'd0;
      end
      return base + {1'b0, units};
   endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational seven-segment decoder: maps one active-low code to {valid, digit}.
module seg_digit_decode
   import seg_pkg::*;
(
   input  logic [6:0] code,
   output digit_t     dec
);

   // Code lookup; anything outside 0..9 is reported invalid
   always_comb begin
      dec = '{valid: 1'b0, digit: 4'd0};
      case (code)
         SEG_0:   dec = '{valid: 1'b1, digit: 4'd0};
         SEG_1:   dec = '{valid: 1'b1, digit: 4'd1};
         SEG_2:   dec = '{valid: 1'b1, digit: 4'd2};
         SEG_3:   dec = '{valid: 1'b1, digit: 4'd3};
         SEG_4:   dec = '{valid: 1'b1, digit: 4'd4};
         SEG_5:   dec = '{valid: 1'b1, digit: 4'd5};
         SEG_6:   dec = '{valid: 1'b1, digit: 4'd6};
         SEG_7:   dec = '{valid: 1'b1, digit: 4'd7};
         SEG_8:   dec = '{valid: 1'b1, digit: 4'd8};
         SEG_9:   dec = '{valid: 1'b1, digit: 4'd9};
         default: dec = '{valid: 1'b0, digit: 4'd0};
      endcase
   end

endmodule

// File: rtl/seg_reader.sv
// Reads a multiplexed two-digit seven-segment bus, debounces complete frames
// and publishes stable values through a valid/ready output register.
module seg_reader
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_N = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_in,
   input  logic [1:0] dig_en,
   input  logic       seg_vld,
   output logic [4:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       err,
   output logic       ovf
);

   localparam logic [3:0] STABLE_C = 4'(STABLE_N);

   rd_state_t  state_r, state_s;
   logic       tens_r, tens_s;
   logic       tens_ok_r, tens_ok_s;
   logic [3:0] cand_r, cand_s;
   logic [3:0] cnt_r, cnt_s;
   logic [3:0] last_r, last_s;
   logic       pubd_r, pubd_s;

   digit_t     dec_s;
   logic       tens_code_ok_s;
   logic       tens_digit_s;
   logic [4:0] frame_s;
   logic       frame_ok_s;
   logic       err_s;
   logic       pub_s;
   logic       ovf_s;
   logic       out_valid_s;
   logic [4:0] out_data_s;

   seg_digit_decode u_dec (
      .code (seg_in),
      .dec  (dec_s)
   );

   // The tens position only accepts blank (0) or the "1" glyph
   assign tens_digit_s   = (seg_in != SEG_BLANK);
   assign tens_code_ok_s = (seg_in == SEG_BLANK) || (dec_s.valid && (dec_s.digit == 4'd1));
   assign frame_s        = frame_value(tens_r, dec_s.digit);
   assign frame_ok_s     = tens_ok_r && dec_s.valid && (frame_s <= 5'd15);

   // Frame sequencing, stability counting and publish decision
   always_comb begin
      state_s   = state_r;
      tens_s    = tens_r;
      tens_ok_s = tens_ok_r;
      cand_s    = cand_r;
      cnt_s     = cnt_r;
      last_s    = last_r;
      pubd_s    = pubd_r;
      err_s     = 1'b0;
      pub_s     = 1'b0;
      if (seg_vld) begin
         case (dig_en)
            DIG_TENS: begin
               tens_s    = tens_digit_s;
               tens_ok_s = tens_code_ok_s;
               state_s   = S_UNITS;
               if (state_r == S_UNITS) begin
                  err_s = 1'b1;
               end else begin
                  err_s = 1'b0;
               end
            end
            DIG_UNITS: begin
               if (state_r == S_TENS) begin
                  err_s = 1'b1;
               end else begin
                  state_s = S_TENS;
                  if (frame_ok_s) begin
                     if (frame_s[3:0] == cand_r) begin
                        if (cnt_r >= STABLE_C) begin
                           cnt_s = STABLE_C;
                        end else begin
                           cnt_s = cnt_r + 4'd1;
                        end
                     end else begin
                        cand_s = frame_s[3:0];
                        cnt_s  = 4'd1;
                     end
                     if ((cnt_s == STABLE_C) && ((cand_s != last_r) || !pubd_r)) begin
                        pub_s  = 1'b1;
                        last_s = cand_s;
                        pubd_s = 1'b1;
                     end else begin
                        pub_s  = 1'b0;
                     end
                  end else begin
                     err_s = 1'b1;
                     cnt_s = 4'd0;
                  end
               end
            end
            default: begin
               err_s   = 1'b1;
               state_s = S_TENS;
               cnt_s   = 4'd0;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Output register next-state: load on publish, clear on handshake
   always_comb begin
      out_data_s  = out_data;
      out_valid_s = out_valid;
      ovf_s       = 1'b0;
      if (pub_s) begin
         out_data_s  = {1'b0, cand_s};
         out_valid_s = 1'b1;
         ovf_s       = out_valid && !out_ready;
      end else if (out_valid && out_ready) begin
         out_valid_s = 1'b0;
      end else begin
         out_valid_s = out_valid;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_TENS;
      end else begin
         state_r <= state_s;
      end
   end

   // Latched tens digit, candidate, stability count and last published value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens_r    <= 1'b0;
         tens_ok_r <= 1'b0;
         cand_r    <= 4'd0;
         cnt_r     <= 4'd0;
         last_r    <= 4'd0;
         pubd_r    <= 1'b0;
      end else begin
         tens_r    <= tens_s;
         tens_ok_r <= tens_ok_s;
         cand_r    <= cand_s;
         cnt_r     <= cnt_s;
         last_r    <= last_s;
         pubd_r    <= pubd_s;
      end
   end

   // Registered outputs and single-cycle status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= 5'd0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         out_data  <= out_data_s;
         out_valid <= out_valid_s;
         err       <= err_s;
         ovf       <= ovf_s;
      end
   end

endmodule

// File: doc/seg_reader.md
SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 Parameter STABLE_N, default 2, number of consecutive identical valid frames required before publishing; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 seg_in  input  7  active-low segment pattern, bit6=a .. bit0=g.
REQ-005 dig_en  input  2  digit select, one-hot: 2'b10 tens, 2'b01 units.
REQ-006 seg_vld  input  1  qualifies seg_in/dig_en for one cycle.
REQ-007 out_data  output  5  decoded value 0..15.
REQ-008 out_valid  output  1  out_data pending; held until out_ready.
REQ-009 out_ready  input  1  consumer accepts out_data when high with out_valid.
REQ-010 err  output  1  one-cycle pulse on any protocol or decode error.
REQ-011 ovf  output  1  one-cycle pulse when a pending value is overwritten.

Function
REQ-012 Tens code mapping: 7'b1111111 (blank) -> 0, 7'b1001111 -> 1; any other tens code is a decode error.
REQ-013 Units code mapping: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9; any other units code is a decode error.
REQ-014 Frame value = tens*10 + units; values 16..19 are decode errors.
REQ-015 FSM states S_TENS (await tens sample) and S_UNITS (await units sample); reset state S_TENS.
REQ-016 S_TENS: seg_vld with dig_en=10 latches tens, -> S_UNITS; dig_en=01 -> err pulse, stay.
REQ-017 S_UNITS: seg_vld with dig_en=01 completes the frame, -> S_TENS; dig_en=10 -> err pulse, relatch tens, stay.
REQ-018 seg_vld with dig_en of 00 or 11 in either state -> err pulse, -> S_TENS, stability count cleared.
REQ-019 Cycles with seg_vld low do not change state.
REQ-020 Valid completed frame: equal to the candidate value -> count increments, saturating at STABLE_N; different -> candidate := frame value, count := 1.
REQ-021 Invalid completed frame -> err pulse, count := 0.
REQ-022 Publish when count reaches STABLE_N and candidate differs from the last published value, or nothing has been published since reset.
REQ-023 Publish: out_data := candidate, out_valid := 1 on the clock edge following the completing units sample (1-cycle latency).
REQ-024 out_valid & out_ready clears out_valid next cycle; out_data holds its value.
REQ-025 Publish while out_valid=1 and out_ready=0: out_data overwritten, out_valid stays 1, ovf pulses.
REQ-026 Publish coinciding with out_valid & out_ready: old value consumed, new value loaded, out_valid stays 1, no ovf.
REQ-027 err and ovf are registered, at most one pulse each per cycle.

Reset
REQ-028 While rst_n low: state S_TENS, count 0, candidate 0, out_data 0, out_valid 0, err 0, ovf 0, published-flag cleared.
REQ-029 Reset asserted mid-frame discards the partial frame and any pending out_valid.

Structure
REQ-030 Shared package seg_pkg holds the 7-bit segment code constants (0..9, blank) and the dig_en encodings; the display driver and seg_reader use the same constants.
REQ-031 Combinational sub-module seg_digit_decode maps a 7-bit code to {valid, 4-bit digit}; one instance serves both positions, with the tens digit further restricted to 0/1.

Verification
REQ-032 STABLE_N=2: two frames tens=1111111/units=0100100 -> out_valid=1, out_data=5 one cycle after the second units sample.
REQ-033 Frames 1001111/0000110 then 1001111/0000000 -> no publish; err pulses once (value 18).
REQ-034 Units sample while in S_TENS -> err pulse, no state change; a following correct frame pair publishes normally.
REQ-035 out_ready=0, stable 12 then stable 7 -> ovf pulse, out_data=7, out_valid held at 1.
REQ-036 rst_n low between tens and units samples -> all outputs 0; a fresh two-frame sequence for 9 publishes 9.
